wb_seg_ctrl: RTL and testbench
==============================

WB_SEG_CTRL -- requirements
Module: wb_seg_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000: word-aligned base of the 16-byte register window.
REQ-002 Parameter DEFAULT_COMPARE, default 24'd10_000_000: reset value of COMPARE.
REQ-003 wb_clk_i  input  1: single clock; all state changes on its rising edge.
REQ-004 wb_rst_i  input  1: synchronous, active-high reset.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each: Wishbone strobe, cycle, write-enable from the management SoC.
REQ-006 wbs_sel_i  input  4: byte lane selects.
REQ-007 wbs_adr_i, wbs_dat_i  input  32 each: byte address, write data.
REQ-008 wbs_ack_o  output  1; wbs_dat_o  output  32: acknowledge, read data.
REQ-009 seg_out  output  7: active-high segments, bit0=a ... bit6=g.
REQ-010 irq  output  1: level interrupt.

Function
REQ-011 Hit = cyc & stb & adr[31:4]==BASE_ADDR[31:4]; register index = adr[3:2]; miss never acks, writes nothing.
REQ-012 Hit with ack low: register ack=1 next cycle, exactly one cycle; ack is 0 on the cycle after any ack, so a held strobe yields ack every second cycle.
REQ-013 Writes commit on the ack cycle, per byte lane where sel=1; reads return data on the ack cycle; wbs_dat_o=0 whenever ack=0.
REQ-014 0x0: CTRL, RW: bit0 RUN, bit1 IRQ_EN; bit2 CLR write-only, self-clearing, reads 0; other bits read 0.
REQ-015 0x4: COMPARE[23:0], RW; bits 31:24 read 0; any write to it clears the prescaler to 0.
REQ-016 0x8: DIGIT[3:0], RO; writes acked, ignored.
REQ-017 0xC: STATUS bit0 WRAP, sticky; writing 1 clears it (W1C); writing 0 no effect.
REQ-018 Prescaler 24 bits; RUN=1: if prescaler>=COMPARE then prescaler<=0 and tick, else increment; tick period = COMPARE+1 cycles (COMPARE=0: tick every cycle).
REQ-019 RUN=0: prescaler and DIGIT hold; no ticks.
REQ-020 Tick: DIGIT increments 0..9; at 9 wraps to 0 and sets WRAP.
REQ-021 CLR write: prescaler<=0, DIGIT<=0 next cycle; CLR beats a same-cycle tick; WRAP unchanged.
REQ-022 WRAP set and W1C in the same cycle: set wins.
REQ-023 seg_out = registered decode of DIGIT, updated one cycle after DIGIT changes; values 10-15 unreachable, decode to 7'h00.
REQ-024 irq = WRAP & IRQ_EN, registered (one cycle after either changes).

Reset
REQ-025 wb_rst_i high on a rising edge: ack=0, dat_o=0, CTRL=0, COMPARE=DEFAULT_COMPARE, prescaler=0, DIGIT=0, WRAP=0, irq=0.
REQ-026 seg_out resets to the decode of digit 0 (7'h3F).
REQ-027 Reset mid-transaction drops any pending ack; the write does not commit.

Configuration
REQ-028 Macro WB_SEG_IRQ_EN: defined -> IRQ_EN bit and irq behave per REQ-014/REQ-024.
REQ-029 Undefined -> CTRL bit1 reads 0 and ignores writes, irq tied 0; WRAP still sets and clears.

Structure
REQ-030 Shared package wb_seg_pkg: register offsets, CTRL bit indices, 7-segment pattern constants for digits 0-9.
REQ-031 One sub-module seg_decoder: combinational 4-bit digit to 7-bit pattern; the registering happens in wb_seg_ctrl.

Verification
REQ-032 Reset, read all four offsets -> 0x0, DEFAULT_COMPARE, 0x0, 0x0; seg_out=7'h3F, irq=0.
REQ-033 Write COMPARE=3, CTRL=1 -> DIGIT increments every 4 cycles; 9->0 sets WRAP after 40 cycles; seg_out follows 1 cycle late.
REQ-034 COMPARE=0, RUN=1, IRQ_EN=1 -> tick each cycle; irq=1 one cycle after WRAP; write STATUS=1 -> irq=0; with the same-cycle wrap, WRAP remains 1.
REQ-035 Write CTRL=0x5 while DIGIT=7 and a tick is due -> DIGIT=0, prescaler=0, RUN stays 1.
REQ-036 Write COMPARE with sel=4'b0001, data 0xAABBCCDD -> COMPARE low byte 0xDD, others unchanged; held strobe -> ack pattern 0,1,0,1.
REQ-037 Access at BASE_ADDR+0x10 -> no ack, no state change; build without WB_SEG_IRQ_EN -> CTRL write 0x3 reads back 0x1, irq stays 0.

Source files
------------

// File: rtl/wb_seg_pkg.sv
// Shared constants for the Wishbone 7-segment counter: register offsets,
// CTRL bit positions and active-high segment patterns (bit0=a ... bit6=g).
package wb_seg_pkg;

    localparam logic [3:0] OFS_CTRL    = 4'h0;
    localparam logic [3:0] OFS_COMPARE = 4'h4;
    localparam logic [3:0] OFS_DIGIT   = 4'h8;
    localparam logic [3:0] OFS_STATUS  = 4'hC;

    localparam int CTRL_RUN_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_CLR_BIT    = 2;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/wb_seg_ctrl_if.sv
// Wishbone slave bus bundle for wb_seg_ctrl; the SoC side uses the master modport.
interface wb_seg_ctrl_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_seg_ctrl_seg_decoder.sv
// Combinational digit-to-segment decoder; codes 10-15 blank the display.
module seg_decoder
    import wb_seg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Digit lookup
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/wb_seg_ctrl.sv
// Wishbone-controlled prescaled decimal counter driving a 7-segment display.
// Optional macro WB_SEG_IRQ_EN adds the CTRL.IRQ_EN bit and the irq output.
module wb_seg_ctrl
    import wb_seg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter logic [23:0] DEFAULT_COMPARE = 24'd10_000_000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wb_seg_ctrl_if.slave  wbs,
    output logic [6:0]    seg_out,
    output logic          irq
);

    logic        r_ack;
    logic [31:0] r_dat_o;
    logic        r_we;
    logic [1:0]  r_idx;
    logic [2:0]  r_sel;
    logic [23:0] r_wdat;

    logic        r_run;
    logic [23:0] r_compare;
    logic [23:0] r_presc;
    logic [3:0]  r_digit;
    logic        r_wrap;
    logic [6:0]  r_seg;
    logic        r_irq;

    logic        w_hit;
    logic        w_launch;
    logic        w_commit;
    logic        w_wr_ctrl;
    logic        w_wr_cmp;
    logic        w_clr;
    logic        w_tick;
    logic        w_wrap_set;
    logic        w_wrap_clr;
    logic        w_irq_en;
    logic [31:0] w_rdata;
    logic [23:0] w_presc_nxt;
    logic [3:0]  w_digit_nxt;
    logic        w_wrap_nxt;
    logic [6:0]  w_seg;
    logic        w_unused;

    assign w_hit    = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_launch = w_hit & ~r_ack;

    // The request is captured when ack is launched, so the commit does not depend on the master holding the bus
    assign w_commit   = r_ack & r_we;
    assign w_wr_ctrl  = w_commit & ({r_idx, 2'b00} == OFS_CTRL) & r_sel[0];
    assign w_wr_cmp   = w_commit & ({r_idx, 2'b00} == OFS_COMPARE);
    assign w_clr      = w_wr_ctrl & r_wdat[CTRL_CLR_BIT];
    assign w_tick     = r_run & (r_presc >= r_compare);
    assign w_wrap_set = w_tick & (r_digit == 4'd9) & ~w_clr;
    assign w_wrap_clr = w_commit & ({r_idx, 2'b00} == OFS_STATUS) & r_sel[0] & r_wdat[0];

`ifdef WB_SEG_IRQ_EN
    logic r_irq_en;

    // Interrupt enable bit of CTRL
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq_en <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_irq_en <= r_wdat[CTRL_IRQ_EN_BIT];
        end
    end

    assign w_irq_en = r_irq_en;
    assign w_unused = ^{wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3], wbs.wbs_dat_i[31:24]};
`else
    assign w_irq_en = 1'b0;
    assign w_unused = ^{wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3], wbs.wbs_dat_i[31:24],
                        r_wdat[CTRL_IRQ_EN_BIT]};
`endif

    // Read mux for the addressed register
    always_comb begin
        w_rdata = 32'd0;
        case ({wbs.wbs_adr_i[3:2], 2'b00})
            OFS_CTRL:    w_rdata = {30'd0, w_irq_en, r_run};
            OFS_COMPARE: w_rdata = {8'd0, r_compare};
            OFS_DIGIT:   w_rdata = {28'd0, r_digit};
            OFS_STATUS:  w_rdata = {31'd0, r_wrap};
            default:     w_rdata = 32'd0;
        endcase
    end

    // Bus handshake: one ack cycle per hit, never two in a row
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack   <= 1'b0;
            r_dat_o <= 32'd0;
            r_we    <= 1'b0;
            r_idx   <= 2'd0;
            r_sel   <= 3'd0;
            r_wdat  <= 24'd0;
        end else begin
            r_ack   <= w_launch;
            r_dat_o <= (w_launch && !wbs.wbs_we_i) ? w_rdata : 32'd0;
            if (w_launch) begin
                r_we   <= wbs.wbs_we_i;
                r_idx  <= wbs.wbs_adr_i[3:2];
                r_sel  <= wbs.wbs_sel_i[2:0];
                r_wdat <= wbs.wbs_dat_i[23:0];
            end
        end
    end

    // Counter next state; CLR outranks a same-cycle tick, WRAP set outranks W1C
    always_comb begin
        w_presc_nxt = r_presc;
        w_digit_nxt = r_digit;
        w_wrap_nxt  = r_wrap;
        if (w_clr || w_wr_cmp) begin
            w_presc_nxt = 24'd0;
        end else if (w_tick) begin
            w_presc_nxt = 24'd0;
        end else if (r_run) begin
            w_presc_nxt = r_presc + 24'd1;
        end else begin
            w_presc_nxt = r_presc;
        end
        if (w_clr) begin
            w_digit_nxt = 4'd0;
        end else if (w_tick) begin
            w_digit_nxt = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
        end else begin
            w_digit_nxt = r_digit;
        end
        if (w_wrap_set) begin
            w_wrap_nxt = 1'b1;
        end else if (w_wrap_clr) begin
            w_wrap_nxt = 1'b0;
        end else begin
            w_wrap_nxt = r_wrap;
        end
    end

    seg_decoder u_seg_decoder (
        .i_digit (r_digit),
        .o_seg   (w_seg)
    );

    // Control/counter state and registered display/interrupt outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_run     <= 1'b0;
            r_compare <= DEFAULT_COMPARE;
            r_presc   <= 24'd0;
            r_digit   <= 4'd0;
            r_wrap    <= 1'b0;
            r_seg     <= SEG_0;
            r_irq     <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_digit <= w_digit_nxt;
            r_wrap  <= w_wrap_nxt;
            r_seg   <= w_seg;
            r_irq   <= r_wrap & w_irq_en;
            if (w_wr_ctrl) begin
                r_run <= r_wdat[CTRL_RUN_BIT];
            end
            if (w_wr_cmp) begin
                if (r_sel[0]) r_compare[7:0]   <= r_wdat[7:0];
                if (r_sel[1]) r_compare[15:8]  <= r_wdat[15:8];
                if (r_sel[2]) r_compare[23:16] <= r_wdat[23:16];
            end
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat_o;
    assign seg_out       = r_seg;
    assign irq           = r_irq;

endmodule

// File: tb/tb_wb_seg_ctrl.sv
// Randomised scoreboard bench for wb_seg_ctrl against a cycle-level reference model.
module tb_wb_seg_ctrl;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [23:0] DEF_CMP = 24'd10_000_000;
`ifdef WB_SEG_IRQ_EN
    localparam bit IRQ_SUP = 1'b1;
`else
    localparam bit IRQ_SUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_out;
    logic       irq;
    bit         started = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    wb_seg_ctrl_if bus();

    wb_seg_ctrl dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus),
        .seg_out  (seg_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic rd; logic [31:0] data; } exp_t;
    exp_t exp_q[$];

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference state
    logic        m_run, m_en, m_wrap, m_irq, m_ack;
    logic [23:0] m_cmp, m_presc;
    logic [3:0]  m_digit;
    logic [6:0]  m_seg;
    logic        p_we;
    logic [1:0]  p_idx;
    logic [3:0]  p_sel;
    logic [31:0] p_dat;

    function automatic logic [31:0] model_read(input logic [1:0] idx);
        case (idx)
            2'd0:    return {30'd0, m_en, m_run};
            2'd1:    return {8'd0, m_cmp};
            2'd2:    return {28'd0, m_digit};
            default: return {31'd0, m_wrap};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: behaviour of one clock edge from the register-level rules
    always @(posedge clk) begin : model
        logic        tick, wset, w1c, hit, n_run, n_en;
        logic [23:0] n_cmp, n_presc;
        logic [3:0]  n_digit;
        if (rst) begin
            m_run <= 1'b0; m_en <= 1'b0; m_wrap <= 1'b0; m_irq <= 1'b0; m_ack <= 1'b0;
            m_cmp <= DEF_CMP; m_presc <= 24'd0; m_digit <= 4'd0; m_seg <= 7'h3F;
            exp_q.delete();
        end else begin
            tick    = m_run && (m_presc >= m_cmp);
            n_presc = !m_run ? m_presc : (tick ? 24'd0 : m_presc + 24'd1);
            n_digit = tick ? 4'((m_digit + 1) % 10) : m_digit;
            wset    = tick && (m_digit == 4'd9);
            w1c     = 1'b0;
            n_run   = m_run;
            n_en    = m_en;
            n_cmp   = m_cmp;
            if (m_ack && p_we) begin
                case (p_idx)
                    2'd0: if (p_sel[0]) begin
                        n_run = p_dat[0];
                        if (IRQ_SUP) n_en = p_dat[1];
                        if (p_dat[2]) begin n_presc = 24'd0; n_digit = 4'd0; wset = 1'b0; end
                    end
                    2'd1: begin
                        for (int b = 0; b < 3; b++) if (p_sel[b]) n_cmp[b*8 +: 8] = p_dat[b*8 +: 8];
                        n_presc = 24'd0;
                    end
                    2'd3: w1c = p_sel[0] && p_dat[0];
                    default: ;
                endcase
            end
            hit = bus.wbs_cyc_i && bus.wbs_stb_i && (bus.wbs_adr_i[31:4] == BASE[31:4]);
            if (hit && !m_ack) begin
                p_we  <= bus.wbs_we_i;
                p_idx <= bus.wbs_adr_i[3:2];
                p_sel <= bus.wbs_sel_i;
                p_dat <= bus.wbs_dat_i;
                exp_q.push_back({!bus.wbs_we_i, model_read(bus.wbs_adr_i[3:2])});
            end
            m_seg   <= (m_digit < 4'd10) ? seg_tab[m_digit] : 7'h00;
            m_irq   <= m_wrap && m_en;
            m_wrap  <= wset ? 1'b1 : (w1c ? 1'b0 : m_wrap);
            m_run   <= n_run;
            m_en    <= n_en;
            m_cmp   <= n_cmp;
            m_presc <= n_presc;
            m_digit <= n_digit;
            m_ack   <= hit && !m_ack;
        end
    end

    // Monitor: compares the bus response and outputs away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            check("ack", {31'd0, bus.wbs_ack_o}, {31'd0, m_ack});
            if (bus.wbs_ack_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.rd) check("rdata", bus.wbs_dat_o, e.data);
                end
            end else begin
                check("dat_idle", bus.wbs_dat_o, 32'd0);
            end
            check("seg_out", {25'd0, seg_out}, {25'd0, m_seg});
            check("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    endtask

    task automatic bus_cycle(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                             input logic [31:0] dat, input bit expect_ack);
        bit got = 1'b0;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_sel_i = sel; bus.wbs_adr_i = adr; bus.wbs_dat_i = dat;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) got = 1'b1;
        end
        bus_idle();
        check(expect_ack ? "ack_timeout" : "miss_acked", {31'd0, got}, {31'd0, expect_ack});
    endtask

    task automatic wr(input logic [3:0] ofs, input logic [31:0] dat);
        bus_cycle(BASE + {28'd0, ofs}, 1'b1, 4'hF, dat, 1'b1);
    endtask

    task automatic rd(input logic [3:0] ofs);
        bus_cycle(BASE + {28'd0, ofs}, 1'b0, 4'hF, 32'd0, 1'b1);
    endtask

    task automatic reset_mid_write(input logic [31:0] dat);
        int i = 0;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE; bus.wbs_dat_i = dat;
        do begin @(negedge clk); i++; end while (!bus.wbs_ack_o && i < 6);
        bus_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0]  pat;
        logic [1:0]  idx;
        logic [31:0] dat;
        int          k;
        bus_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        rd(4'h0); rd(4'h4); rd(4'h8); rd(4'hC);

        // COMPARE=3, RUN: tick every 4 cycles, wrap after 40
        wr(4'h4, 32'd3); wr(4'h0, 32'd1);
        repeat (45) @(negedge clk);
        rd(4'hC); rd(4'h8);

        // CLR while DIGIT=7 and a tick is due on the commit edge
        k = 0;
        while (!(m_digit == 4'd7 && m_presc == 24'd1) && k < 200) begin @(negedge clk); k++; end
        check("clr_setup_timeout", {31'd0, (k < 200)}, 32'd1);
        wr(4'h0, 32'h5);
        rd(4'h8); rd(4'h0);

        // COMPARE=0 with IRQ_EN, then W1C races against wraps
        wr(4'h4, 32'd0); wr(4'h0, 32'h3);
        repeat (15) @(negedge clk);
        for (int n = 0; n < 25; n++) begin
            wr(4'hC, 32'd1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rd(4'hC);

        // Byte-lane write with held strobe: ack 0,1,0,1
        wr(4'h0, 32'h0);
        wr(4'h4, 32'h0012_3456);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_sel_i = 4'b0001; bus.wbs_adr_i = BASE + 32'h4; bus.wbs_dat_i = 32'hAABB_CCDD;
        for (int i = 0; i < 4; i++) begin
            pat[i] = bus.wbs_ack_o;
            @(negedge clk);
        end
        bus_idle();
        check("held_stb_ack_pattern", {28'd0, pat}, 32'h0000_000A);
        rd(4'h4);

        // Out-of-window accesses, CTRL IRQ_EN readback
        bus_cycle(BASE + 32'h10, 1'b1, 4'hF, 32'h7, 1'b0);
        bus_cycle(BASE + 32'h1C, 1'b0, 4'hF, 32'h0, 1'b0);
        bus_cycle(32'h2000_0000, 1'b1, 4'hF, 32'h1, 1'b0);
        wr(4'h0, 32'h3); rd(4'h0); rd(4'h4);

        // Reset in the middle of a write
        reset_mid_write(32'h1);
        rd(4'h0);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            k   = $urandom_range(0, 24);
            idx = 2'($urandom_range(0, 3));
            dat = $urandom;
            if (idx == 2'd1 && $urandom_range(0, 3) != 0) dat = $urandom_range(0, 6);
            if (idx == 2'd0 && $urandom_range(0, 3) != 0) dat[0] = 1'b1;
            if (k == 0) begin
                bus_cycle(BASE + 32'h10 + {28'd0, idx, 2'b00}, 1'($urandom_range(0, 1)), 4'hF, dat, 1'b0);
            end else if (k == 1) begin
                reset_mid_write(dat);
            end else begin
                bus_cycle(BASE + {28'd0, idx, 2'b00}, 1'($urandom_range(0, 1)), 4'($urandom), dat, 1'b1);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
